// File: rtl/lotr_pkg.sv
// lotr_pkg: ring opcode, slot layout and core-ID field positions shared by the ring stop
package lotr_pkg;
  typedef enum logic [1:0] {RD = 2'd0, WR = 2'd1, RD_RSP = 2'd2} t_opcode;
  localparam int MSB_CORE_ID = 31;
  localparam int LSB_CORE_ID = 24;
  localparam int RING_REQ_W = 10;
  typedef struct packed {
    logic valid;
    t_opcode opcode;
    logic [RING_REQ_W-1:0] requestor;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_slot;
endpackage

// File: rtl/ring_fifo.sv
// ring_fifo: circular buffer, naturally wrapping pointers, extra count bit tells full from empty
module ring_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/ring_stop_ctrl.sv
// ring_stop_ctrl: per-core ring stop; injects core requests and local read responses,
// consumes ring traffic addressed to this core, forwards everything else one hop later
module ring_stop_ctrl import lotr_pkg::*; #(
  parameter int C2F_FIFO_DEPTH = 4,
  parameter int F2C_FIFO_DEPTH = 4
) (
  input  logic QClk,
  input  logic RstQnnnH,
  input  logic [7:0] CoreIdStrap,
  input  logic C2F_ReqValidQ500H,
  input  t_opcode C2F_ReqOpcodeQ500H,
  input  logic [1:0] C2F_ReqThreadIDQ500H,
  input  logic [31:0] C2F_ReqAddressQ500H,
  input  logic [31:0] C2F_ReqDataQ500H,
  output logic C2F_RspStall,
  output logic C2F_RspValidQ502H,
  output t_opcode C2F_RspOpcodeQ502H,
  output logic [1:0] C2F_RspThreadIDQ502H,
  output logic [31:0] C2F_RspDataQ502H,
  output logic F2C_ReqValidQ503H,
  output t_opcode F2C_ReqOpcodeQ503H,
  output logic [31:0] F2C_ReqAddressQ503H,
  output logic [31:0] F2C_ReqDataQ503H,
  input  logic F2C_RspDMemValidQ504H,
  input  logic [31:0] F2C_D_MemRspDataQ504H,
  input  logic RingInValid,
  input  t_opcode RingInOpcode,
  input  logic [RING_REQ_W-1:0] RingInRequestor,
  input  logic [31:0] RingInAddress,
  input  logic [31:0] RingInData,
  output logic RingOutValid,
  output t_opcode RingOutOpcode,
  output logic [RING_REQ_W-1:0] RingOutRequestor,
  output logic [31:0] RingOutAddress,
  output logic [31:0] RingOutData
);
  localparam int CW = $clog2(C2F_FIFO_DEPTH) + 1;
  localparam int FW = $clog2(F2C_FIFO_DEPTH) + 1;
  localparam int CE = 68;
  localparam int FE = RING_REQ_W + 32;
  logic [CW-1:0] w_c2f_count;
  logic [FW-1:0] w_f2c_count, r_inflight;
  logic [CE-1:0] w_c2f_in, w_c2f_head, w_c2f_sel;
  logic [FE-1:0] w_f2c_head, w_f2c_sel;
  logic w_c2f_full, w_c2f_empty, w_f2c_full, w_f2c_empty;
  logic w_cons_rsp, w_cons_req, w_cons_rd, w_rd_ok, w_slot_free, w_rsp_dec;
  logic w_inj_f2c, w_inj_c2f, w_c2f_push, w_c2f_pop, w_f2c_push, w_f2c_pop;
  logic [RING_REQ_W-1:0] r_rq0, r_rq1;
  t_ring_slot w_out, r_out;
  logic r_rsp_v, r_req_v;
  t_opcode r_rsp_op, r_req_op;
  logic [1:0] r_rsp_tid;
  logic [31:0] r_rsp_data, r_req_addr, r_req_data;
  assign w_rd_ok = ({1'b0, w_f2c_count} + {1'b0, r_inflight}) < (FW+1)'(F2C_FIFO_DEPTH);
  assign w_cons_rsp = RingInValid && RingInOpcode == RD_RSP && RingInRequestor[RING_REQ_W-1:2] == CoreIdStrap;
  assign w_cons_req = RingInValid && RingInAddress[MSB_CORE_ID:LSB_CORE_ID] == CoreIdStrap
                      && (RingInOpcode == WR || (RingInOpcode == RD && w_rd_ok));
  assign w_cons_rd = w_cons_req && RingInOpcode == RD;
  assign w_slot_free = !RingInValid || w_cons_rsp || w_cons_req;
  assign w_rsp_dec = F2C_RspDMemValidQ504H && |r_inflight;
  // An empty FIFO is bypassed so fresh read data or a fresh core request can leave in the same cycle
  assign w_f2c_sel = w_f2c_empty ? {r_rq1, F2C_D_MemRspDataQ504H} : w_f2c_head;
  assign w_c2f_in = {C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H, C2F_ReqAddressQ500H, C2F_ReqDataQ500H};
  assign w_c2f_sel = w_c2f_empty ? w_c2f_in : w_c2f_head;
  assign w_inj_f2c = w_slot_free && (!w_f2c_empty || F2C_RspDMemValidQ504H);
  assign w_inj_c2f = w_slot_free && !w_inj_f2c && (!w_c2f_empty || C2F_ReqValidQ500H);
  assign w_f2c_push = F2C_RspDMemValidQ504H && !(w_f2c_empty && w_inj_f2c);
  assign w_f2c_pop = w_inj_f2c && !w_f2c_empty;
  assign w_c2f_push = C2F_ReqValidQ500H && !(w_c2f_empty && w_inj_c2f);
  assign w_c2f_pop = w_inj_c2f && !w_c2f_empty;
  assign C2F_RspStall = w_c2f_count >= CW'(C2F_FIFO_DEPTH - 1);
  assign w_out = !w_slot_free ? t_ring_slot'{valid: 1'b1, opcode: RingInOpcode, requestor: RingInRequestor,
                                             address: RingInAddress, data: RingInData}
               : w_inj_f2c ? t_ring_slot'{valid: 1'b1, opcode: RD_RSP, requestor: w_f2c_sel[FE-1:32],
                                          address: 32'h0, data: w_f2c_sel[31:0]}
               : w_inj_c2f ? t_ring_slot'{valid: 1'b1, opcode: t_opcode'(w_c2f_sel[67:66]),
                                          requestor: {CoreIdStrap, w_c2f_sel[65:64]},
                                          address: w_c2f_sel[63:32], data: w_c2f_sel[31:0]}
               : t_ring_slot'('0);
  ring_fifo #(.W(CE), .DEPTH(C2F_FIFO_DEPTH)) u_c2f (
    .i_clk(QClk), .i_rst(RstQnnnH), .i_push(w_c2f_push), .i_pop(w_c2f_pop), .i_data(w_c2f_in),
    .o_data(w_c2f_head), .o_full(w_c2f_full), .o_empty(w_c2f_empty), .o_count(w_c2f_count)
  );
  ring_fifo #(.W(FE), .DEPTH(F2C_FIFO_DEPTH)) u_f2c (
    .i_clk(QClk), .i_rst(RstQnnnH), .i_push(w_f2c_push), .i_pop(w_f2c_pop), .i_data({r_rq1, F2C_D_MemRspDataQ504H}),
    .o_data(w_f2c_head), .o_full(w_f2c_full), .o_empty(w_f2c_empty), .o_count(w_f2c_count)
  );
  always_ff @(posedge QClk)
    if (RstQnnnH) begin
      r_out <= '0;
      r_rsp_v <= 1'b0;
      r_rsp_op <= RD;
      r_rsp_tid <= '0;
      r_rsp_data <= '0;
      r_req_v <= 1'b0;
      r_req_op <= RD;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_rq0 <= '0;
      r_rq1 <= '0;
      r_inflight <= '0;
    end else begin
      r_out <= w_out;
      r_rsp_v <= w_cons_rsp;
      r_rsp_op <= w_cons_rsp ? RD_RSP : RD;
      r_rsp_tid <= w_cons_rsp ? RingInRequestor[1:0] : 2'b0;
      r_rsp_data <= w_cons_rsp ? RingInData : 32'h0;
      r_req_v <= w_cons_req;
      r_req_op <= w_cons_req ? RingInOpcode : RD;
      r_req_addr <= w_cons_req ? RingInAddress : 32'h0;
      r_req_data <= w_cons_req ? RingInData : 32'h0;
      r_rq0 <= w_cons_rd ? RingInRequestor : '0;
      r_rq1 <= r_rq0;
      r_inflight <= r_inflight + FW'(w_cons_rd) - FW'(w_rsp_dec);
    end
  always_ff @(posedge QClk)
    if (!RstQnnnH) begin
      assert (!(C2F_ReqValidQ500H && w_c2f_full));
      assert (!(w_f2c_push && w_f2c_full));
    end
  assign RingOutValid = r_out.valid;
  assign RingOutOpcode = r_out.opcode;
  assign RingOutRequestor = r_out.requestor;
  assign RingOutAddress = r_out.address;
  assign RingOutData = r_out.data;
  assign C2F_RspValidQ502H = r_rsp_v;
  assign C2F_RspOpcodeQ502H = r_rsp_op;
  assign C2F_RspThreadIDQ502H = r_rsp_tid;
  assign C2F_RspDataQ502H = r_rsp_data;
  assign F2C_ReqValidQ503H = r_req_v;
  assign F2C_ReqOpcodeQ503H = r_req_op;
  assign F2C_ReqAddressQ503H = r_req_addr;
  assign F2C_ReqDataQ503H = r_req_data;
endmodule

// File: tb/tb_ring_stop_ctrl.sv
// tb_ring_stop_ctrl: directed checks of ring stop injection, consumption and reset
module tb_ring_stop_ctrl;
  import lotr_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] core_id = 8'h02;
  logic c2f_v = 1'b0;
  t_opcode c2f_op = RD;
  logic [1:0] c2f_tid = '0;
  logic [31:0] c2f_a = '0, c2f_d = '0;
  logic stall, rsp_v, f2c_v, rout_v;
  t_opcode rsp_op, f2c_op, rout_op;
  logic [1:0] rsp_tid;
  logic [31:0] rsp_d, f2c_a, f2c_d, rout_a, rout_d;
  logic q504_v = 1'b0;
  logic [31:0] q504_d = '0;
  logic rin_v = 1'b0;
  t_opcode rin_op = RD;
  logic [9:0] rin_rq = '0, rout_rq;
  logic [31:0] rin_a = '0, rin_d = '0;
  logic [76:0] rout;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign rout = {rout_v, rout_op, rout_rq, rout_a, rout_d};
  ring_stop_ctrl dut (
    .QClk(clk), .RstQnnnH(rst), .CoreIdStrap(core_id),
    .C2F_ReqValidQ500H(c2f_v), .C2F_ReqOpcodeQ500H(c2f_op), .C2F_ReqThreadIDQ500H(c2f_tid),
    .C2F_ReqAddressQ500H(c2f_a), .C2F_ReqDataQ500H(c2f_d), .C2F_RspStall(stall),
    .C2F_RspValidQ502H(rsp_v), .C2F_RspOpcodeQ502H(rsp_op), .C2F_RspThreadIDQ502H(rsp_tid),
    .C2F_RspDataQ502H(rsp_d), .F2C_ReqValidQ503H(f2c_v), .F2C_ReqOpcodeQ503H(f2c_op),
    .F2C_ReqAddressQ503H(f2c_a), .F2C_ReqDataQ503H(f2c_d),
    .F2C_RspDMemValidQ504H(q504_v), .F2C_D_MemRspDataQ504H(q504_d),
    .RingInValid(rin_v), .RingInOpcode(rin_op), .RingInRequestor(rin_rq), .RingInAddress(rin_a), .RingInData(rin_d),
    .RingOutValid(rout_v), .RingOutOpcode(rout_op), .RingOutRequestor(rout_rq), .RingOutAddress(rout_a), .RingOutData(rout_d)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic ring(input logic v, input t_opcode op, input logic [9:0] rq, input logic [31:0] a, input logic [31:0] d);
    rin_v = v;
    rin_op = op;
    rin_rq = rq;
    rin_a = a;
    rin_d = d;
  endtask
  task automatic core(input logic v, input t_opcode op, input logic [1:0] tid, input logic [31:0] a, input logic [31:0] d);
    c2f_v = v;
    c2f_op = op;
    c2f_tid = tid;
    c2f_a = a;
    c2f_d = d;
  endtask
  function automatic logic [79:0] slot(input logic v, input t_opcode op, input logic [9:0] rq, input logic [31:0] a, input logic [31:0] d);
    return {3'b0, v, op, rq, a, d};
  endfunction
  initial begin
    tick;
    tick;
    chk("rst_ring", rout, 80'h0);
    chk("rst_ctl", {rsp_v, f2c_v, stall}, 3'b000);
    chk("rst_data", {rsp_d, f2c_a}, 64'h0);
    rst = 1'b0;
    core(1, RD, 2'd1, 32'h05400010, 32'h0);
    tick;
    core(0, RD, 2'd0, 32'h0, 32'h0);
    chk("c2f_rd_out", rout, slot(1, RD, 10'h009, 32'h05400010, 32'h0));
    ring(1, RD_RSP, 10'h009, 32'h0, 32'hDEADBEEF);
    tick;
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    chk("c2f_rsp", {rsp_v, rsp_op, rsp_tid, rsp_d}, {1'b1, RD_RSP, 2'd1, 32'hDEADBEEF});
    chk("c2f_rsp_consumed", rout_v, 1'b0);
    tick;
    chk("c2f_rsp_pulse", rsp_v, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ring(1, (i % 2) ? WR : RD, 10'h0C3, 32'h07000000 + 32'(i), 32'h1000 + 32'(i));
      if (i < 4) core(1, WR, 2'd2, 32'h03000000 + 32'(4 * i), 32'hA0 + 32'(i));
      else core(0, RD, 2'd0, 32'h0, 32'h0);
      tick;
      chk($sformatf("pass%0d", i), rout, slot(1, (i % 2) ? WR : RD, 10'h0C3, 32'h07000000 + 32'(i), 32'h1000 + 32'(i)));
      chk($sformatf("stall%0d", i), stall, i >= 2);
    end
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    tick;
    chk("drain0", rout, slot(1, WR, 10'h00A, 32'h03000000, 32'hA0));
    chk("stall_hold", stall, 1'b1);
    tick;
    chk("drain1", rout, slot(1, WR, 10'h00A, 32'h03000004, 32'hA1));
    chk("stall_rel", stall, 1'b0);
    core(1, WR, 2'd2, 32'h03000010, 32'hA4);
    tick;
    core(0, RD, 2'd0, 32'h0, 32'h0);
    chk("drain2", rout, slot(1, WR, 10'h00A, 32'h03000008, 32'hA2));
    tick;
    chk("drain3", rout, slot(1, WR, 10'h00A, 32'h0300000C, 32'hA3));
    tick;
    chk("drain4", rout, slot(1, WR, 10'h00A, 32'h03000010, 32'hA4));
    tick;
    chk("drain_idle", rout_v, 1'b0);
    ring(1, RD, 10'h0C3, 32'h02400020, 32'h0);
    tick;
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    chk("f2c_rd_req", {f2c_v, f2c_op, f2c_a, f2c_d}, {1'b1, RD, 32'h02400020, 32'h0});
    chk("f2c_rd_consumed", rout_v, 1'b0);
    tick;
    chk("f2c_rd_pulse", f2c_v, 1'b0);
    q504_v = 1'b1;
    q504_d = 32'h12345678;
    tick;
    q504_v = 1'b0;
    chk("f2c_rd_rsp", rout, slot(1, RD_RSP, 10'h0C3, 32'h0, 32'h12345678));
    ring(1, WR, 10'h0C3, 32'h02000100, 32'h55);
    tick;
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    chk("f2c_wr_req", {f2c_v, f2c_op, f2c_a, f2c_d}, {1'b1, WR, 32'h02000100, 32'h55});
    chk("f2c_wr_consumed", rout_v, 1'b0);
    tick;
    chk("f2c_wr_norsp", {f2c_v, rout_v}, 2'b00);
    ring(1, RD, 10'h0D1, 32'h02000040, 32'h0);
    tick;
    chk("prio_rd", {f2c_v, rout_v}, 2'b10);
    ring(1, WR, 10'h0C3, 32'h07000100, 32'h11);
    core(1, RD, 2'd3, 32'h04000080, 32'h0);
    tick;
    core(0, RD, 2'd0, 32'h0, 32'h0);
    chk("prio_pass1", rout, slot(1, WR, 10'h0C3, 32'h07000100, 32'h11));
    ring(1, WR, 10'h0C3, 32'h07000104, 32'h22);
    q504_v = 1'b1;
    q504_d = 32'hCAFEF00D;
    tick;
    q504_v = 1'b0;
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    chk("prio_pass2", rout, slot(1, WR, 10'h0C3, 32'h07000104, 32'h22));
    tick;
    chk("prio_f2c_first", rout, slot(1, RD_RSP, 10'h0D1, 32'h0, 32'hCAFEF00D));
    tick;
    chk("prio_c2f_next", rout, slot(1, RD, 10'h00B, 32'h04000080, 32'h0));
    for (int i = 0; i < 4; i++) begin
      ring(1, RD, 10'h100 + 10'(i), 32'h02000000 + 32'(4 * i), 32'h0);
      tick;
      chk($sformatf("full_acc%0d", i), f2c_v, 1'b1);
    end
    ring(1, RD, 10'h1FF, 32'h02000010, 32'h77);
    tick;
    chk("full_fwd", rout, slot(1, RD, 10'h1FF, 32'h02000010, 32'h77));
    chk("full_noreq", f2c_v, 1'b0);
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    q504_v = 1'b1;
    q504_d = 32'h0BADF00D;
    tick;
    q504_v = 1'b0;
    chk("full_rsp", {rout_v, rout_op, rout_d}, {1'b1, RD_RSP, 32'h0BADF00D});
    ring(1, RD, 10'h1FF, 32'h02000010, 32'h77);
    tick;
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    chk("full_lap2", {f2c_v, f2c_op, f2c_a, f2c_d}, {1'b1, RD, 32'h02000010, 32'h77});
    chk("full_lap2_consumed", rout_v, 1'b0);
    ring(1, WR, 10'h0C3, 32'h07000200, 32'h33);
    q504_v = 1'b1;
    q504_d = 32'h5555AAAA;
    tick;
    q504_v = 1'b0;
    chk("rst_pre_pass", rout, slot(1, WR, 10'h0C3, 32'h07000200, 32'h33));
    for (int i = 0; i < 3; i++) begin
      core(1, WR, 2'd0, 32'h03000100 + 32'(4 * i), 32'hB0 + 32'(i));
      tick;
    end
    core(0, RD, 2'd0, 32'h0, 32'h0);
    chk("rst_pre_stall", stall, 1'b1);
    ring(0, RD, 10'h0, 32'h0, 32'h0);
    rst = 1'b1;
    tick;
    chk("midrst_ring", rout, 80'h0);
    chk("midrst_ctl", {rsp_v, f2c_v, stall}, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("postrst_idle%0d", i), rout_v, 1'b0);
    end
    core(1, RD, 2'd0, 32'h06000000, 32'h0);
    tick;
    core(0, RD, 2'd0, 32'h0, 32'h0);
    chk("postrst_c2f", rout, slot(1, RD, 10'h008, 32'h06000000, 32'h0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
